// File: rtl/csr_exec_unit.sv
// CSR execution stage: in-order issue FIFO, S1 operand/forwarding logic, one S2 register stage
// that drives the CSR write port, and a registered completion/wakeup broadcast.
module csr_exec_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [129:0] issue_in,
  input  logic         flush,
  output logic [7:0]   prf_rd_addr,
  input  logic [31:0]  prf_rd_data,
  output logic         csr_wr_valid,
  input  logic         csr_wr_ready,
  output logic [11:0]  csr_wr_addr,
  output logic [31:0]  csr_wr_data,
  output logic         CSR_done,
  output logic [7:0]   CSR_phy,
  output logic [31:0]  CSR_result,
  output logic [31:0]  CSR_inst_num,
  output logic         CSR_exc,
  output logic         fifo_full,
  output logic         overflow
);

  // Handshake: S2 raises csr_wr_valid with addr/data and holds all three stable until a rising
  // edge sees csr_wr_valid & csr_wr_ready; that edge is the write and S2 may reload on it.

  logic [128:0]     fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             empty, full, push, push_ok, pop;

  logic [128:0] head;
  logic [7:0]   h_op1, h_rd;
  logic [31:0]  h_inst, h_csr, h_imm;
  logic [3:0]   h_aluop;
  logic         h_src2;
  logic [11:0]  h_addr;
  logic         imm_hi_unused;

  logic [31:0]  src, old_val, new_val;
  logic         legal_op, wr_intent, s1_illegal, s1_we;

  logic         s2_vld_q, s2_we_q, s2_exc_q;
  logic [11:0]  s2_addr_q;
  logic [31:0]  s2_new_q, s2_old_q, s2_inst_q;
  logic [7:0]   s2_rd_q;
  logic         s2_done;

  logic         last_vld_q;
  logic [11:0]  last_addr_q;
  logic [31:0]  last_data_q;

  logic         done_q, exc_q, ovf_q;
  logic [7:0]   phy_q;
  logic [31:0]  result_q, inst_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign push    = issue_in[129];
  assign s2_done = s2_vld_q & (~s2_we_q | csr_wr_ready);
  assign pop     = ~empty & (~s2_vld_q | s2_done);
  assign push_ok = push & (~full | pop);

  assign head    = fifo_q[rd_ptr_q];
  assign h_op1   = head[128:121];
  assign h_inst  = head[120:89];
  assign h_rd    = head[88:81];
  assign h_aluop = head[80:77];
  assign h_src2  = head[76];
  assign h_csr   = head[75:44];
  assign h_addr  = head[43:32];
  assign h_imm   = head[31:0];
  assign imm_hi_unused = ^h_imm[31:5];

  assign prf_rd_addr = empty ? 8'h00 : h_op1;

  // S1: operand select, old-value forwarding (in-flight S2 beats last committed write), new value
  always_comb begin
    src        = h_src2 ? {27'b0, h_imm[4:0]} : prf_rd_data;
    legal_op   = (h_aluop == 4'h1) || (h_aluop == 4'h2) || (h_aluop == 4'h3);
    wr_intent  = (h_aluop == 4'h1) || (src != 32'h0);
    s1_illegal = ~legal_op || ((h_addr[11:10] == 2'b11) && wr_intent);
    s1_we      = ~s1_illegal && wr_intent;
    if (s2_vld_q && s2_we_q && (s2_addr_q == h_addr))
      old_val = s2_new_q;
    else if (last_vld_q && (last_addr_q == h_addr))
      old_val = last_data_q;
    else
      old_val = h_csr;
    case (h_aluop)
      4'h1:    new_val = src;
      4'h2:    new_val = old_val | src;
      4'h3:    new_val = old_val & ~src;
      default: new_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) fifo_q[wr_ptr_q] <= issue_in[128:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_we_q     <= 1'b0;
      s2_exc_q    <= 1'b0;
      s2_addr_q   <= '0;
      s2_new_q    <= '0;
      s2_old_q    <= '0;
      s2_inst_q   <= '0;
      s2_rd_q     <= '0;
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
      done_q      <= 1'b0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      phy_q       <= '0;
      result_q    <= '0;
      inst_q      <= '0;
    end else begin
      if (csr_wr_valid && csr_wr_ready) begin
        last_vld_q  <= 1'b1;
        last_addr_q <= s2_addr_q;
        last_data_q <= s2_new_q;
      end
      done_q <= s2_done & ~flush;
      if (s2_done && !flush) begin
        exc_q    <= s2_exc_q;
        phy_q    <= s2_rd_q;
        result_q <= s2_exc_q ? 32'h0 : s2_old_q;
        inst_q   <= s2_inst_q;
      end
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        s2_vld_q <= 1'b0;
      end else begin
        if (push && full && !pop) ovf_q <= 1'b1;
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push_ok && !pop) count_q <= count_q + 1'b1;
        else if (pop && !push_ok) count_q <= count_q - 1'b1;
        if (pop) begin
          s2_vld_q  <= 1'b1;
          s2_we_q   <= s1_we;
          s2_exc_q  <= s1_illegal;
          s2_addr_q <= h_addr;
          s2_new_q  <= new_val;
          s2_old_q  <= old_val;
          s2_inst_q <= h_inst;
          s2_rd_q   <= h_rd;
        end else if (s2_done) begin
          s2_vld_q <= 1'b0;
        end
      end
    end
  end

  assign csr_wr_valid = s2_vld_q & s2_we_q;
  assign csr_wr_addr  = s2_addr_q;
  assign csr_wr_data  = s2_new_q;
  assign CSR_done     = done_q;
  assign CSR_phy      = phy_q;
  assign CSR_result   = result_q;
  assign CSR_inst_num = inst_q;
  assign CSR_exc      = exc_q;
  assign fifo_full    = full;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: write/done monitors feed observed queues that each scenario
// task compares against its hand-computed expected queue.
module tb_csr_exec_unit;

  logic         clk, reset, flush, csr_wr_ready;
  logic [129:0] issue_in;
  logic [7:0]   prf_rd_addr, CSR_phy;
  logic [31:0]  prf_rd_data, csr_wr_data, CSR_result, CSR_inst_num;
  logic [11:0]  csr_wr_addr;
  logic         csr_wr_valid, CSR_done, CSR_exc, fifo_full, overflow;

  logic [31:0]  prf_mem [256];
  logic [43:0]  wr_q[$];
  logic [72:0]  done_q[$];
  logic [72:0]  exp_q[$];
  logic [43:0]  exp_wr_q[$];
  int n_checks = 0;
  int n_pass = 0;

  csr_exec_unit #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .issue_in(issue_in), .flush(flush),
    .prf_rd_addr(prf_rd_addr), .prf_rd_data(prf_rd_data),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
    .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .CSR_done(CSR_done), .CSR_phy(CSR_phy), .CSR_result(CSR_result),
    .CSR_inst_num(CSR_inst_num), .CSR_exc(CSR_exc),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prf_rd_data = prf_mem[prf_rd_addr];

  always @(posedge clk)
    if (reset && csr_wr_valid && csr_wr_ready) wr_q.push_back({csr_wr_addr, csr_wr_data});
  always @(negedge clk)
    if (CSR_done) done_q.push_back({CSR_exc, CSR_phy, CSR_result, CSR_inst_num});

  function automatic logic [129:0] mk(input logic [7:0] op1, input logic [31:0] inst,
                                      input logic [7:0] rd, input logic [3:0] op, input logic s2,
                                      input logic [31:0] cd, input logic [11:0] addr,
                                      input logic [31:0] imm);
    return {1'b1, op1, inst, rd, op, s2, cd, addr, imm};
  endfunction

  // driver tasks
  task automatic push_pkt(input logic [129:0] p);
    issue_in = p;
    @(posedge clk); #1;
    issue_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q;
    wr_q.delete(); done_q.delete(); exp_q.delete(); exp_wr_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle(2);
    n_checks++;
    if ({csr_wr_valid, CSR_done, CSR_exc, fifo_full, overflow} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {csr_wr_valid, CSR_done, CSR_exc, fifo_full, overflow});
    else n_pass++;
    n_checks++;
    if ({CSR_phy, CSR_result, CSR_inst_num, csr_wr_addr, csr_wr_data, prf_rd_addr} !== '0)
      $display("FAIL reset_data: got %h want 0", {CSR_phy, CSR_result, CSR_inst_num, csr_wr_addr, csr_wr_data});
    else n_pass++;
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_single_rw;
    clear_q();
    csr_wr_ready = 1'b1;
    prf_mem[3] = 32'hDEAD_BEEF;
    push_pkt(mk(8'd3, 32'd100, 8'd9, 4'h1, 1'b0, 32'h1, 12'h300, 32'h0));
    n_checks++;
    if (prf_rd_addr !== 8'd3) $display("FAIL t1_prf_addr: got %0d want 3", prf_rd_addr); else n_pass++;
    n_checks++;
    if (csr_wr_valid !== 1'b0) $display("FAIL t1_valid_t0: got %b want 0", csr_wr_valid); else n_pass++;
    idle(1);
    n_checks++;
    if ({csr_wr_valid, csr_wr_addr, csr_wr_data} !== {1'b1, 12'h300, 32'hDEAD_BEEF})
      $display("FAIL t1_write: got %b %h %h want 1 300 deadbeef", csr_wr_valid, csr_wr_addr, csr_wr_data);
    else n_pass++;
    n_checks++;
    if (CSR_done !== 1'b0) $display("FAIL t1_done_early: got %b want 0", CSR_done); else n_pass++;
    idle(1);
    n_checks++;
    if ({CSR_done, CSR_exc, CSR_phy, CSR_result, CSR_inst_num} !== {1'b1, 1'b0, 8'd9, 32'h1, 32'd100})
      $display("FAIL t1_done: got %b %b %0d %h %0d want 1 0 9 1 100", CSR_done, CSR_exc, CSR_phy, CSR_result, CSR_inst_num);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({CSR_done, CSR_result} !== {1'b0, 32'h1})
      $display("FAIL t1_done_pulse: got %b %h want 0 1", CSR_done, CSR_result);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    clear_q();
    csr_wr_ready = 1'b1;
    push_pkt(mk(8'd0, 32'd20, 8'd10, 4'h2, 1'b1, 32'h0, 12'h305, 32'd5));
    push_pkt(mk(8'd0, 32'd21, 8'd11, 4'h3, 1'b1, 32'h0, 12'h305, 32'd1));
    idle(6);
    exp_wr_q = '{{12'h305, 32'h5}, {12'h305, 32'h4}};
    exp_q = '{{1'b0, 8'd10, 32'h0, 32'd20}, {1'b0, 8'd11, 32'h5, 32'd21}};
    n_checks++;
    if (wr_q.size() !== 2 || done_q.size() !== 2)
      $display("FAIL t2_counts: got wr=%0d done=%0d want 2 2", wr_q.size(), done_q.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wr_q[i] !== exp_wr_q[i]) $display("FAIL t2_wr%0d: got %h want %h", i, wr_q[i], exp_wr_q[i]);
      else n_pass++;
      n_checks++;
      if (done_q[i] !== exp_q[i]) $display("FAIL t2_done%0d: got %h want %h", i, done_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall_overflow;
    clear_q();
    csr_wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_pkt(mk(8'd0, 32'(200 + i), 8'(30 + i), 4'h1, 1'b1, 32'(32'h11 * i), 12'(12'h340 + i), 32'(i + 1)));
      if (i == 4) begin
        n_checks++;
        if ({fifo_full, overflow} !== 2'b10) $display("FAIL t3_full: got %b want 10", {fifo_full, overflow});
        else n_pass++;
      end
    end
    n_checks++;
    if ({fifo_full, overflow} !== 2'b11) $display("FAIL t3_overflow: got %b want 11", {fifo_full, overflow});
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({csr_wr_valid, csr_wr_addr, csr_wr_data} !== {1'b1, 12'h340, 32'h1})
        $display("FAIL t3_hold%0d: got %b %h %h want 1 340 1", c, csr_wr_valid, csr_wr_addr, csr_wr_data);
      else n_pass++;
      idle(1);
    end
    csr_wr_ready = 1'b1;
    idle(8);
    for (int i = 0; i < 5; i++) begin
      exp_wr_q.push_back({12'(12'h340 + i), 32'(i + 1)});
      exp_q.push_back({1'b0, 8'(30 + i), 32'(32'h11 * i), 32'(200 + i)});
    end
    n_checks++;
    if (wr_q.size() !== 5 || done_q.size() !== 5)
      $display("FAIL t3_counts: got wr=%0d done=%0d want 5 5", wr_q.size(), done_q.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (wr_q[i] !== exp_wr_q[i] || done_q[i] !== exp_q[i])
        $display("FAIL t3_order%0d: got %h/%h want %h/%h", i, wr_q[i], done_q[i], exp_wr_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({fifo_full, overflow} !== 2'b01) $display("FAIL t3_sticky: got %b want 01", {fifo_full, overflow});
    else n_pass++;
  endtask

  task automatic test_illegal;
    clear_q();
    csr_wr_ready = 1'b1;
    push_pkt(mk(8'd0, 32'd300, 8'd50, 4'h1, 1'b1, 32'h9, 12'hC00, 32'd3));
    push_pkt(mk(8'd0, 32'd301, 8'd51, 4'h7, 1'b1, 32'h9, 12'h340, 32'd3));
    idle(6);
    exp_q = '{{1'b1, 8'd50, 32'h0, 32'd300}, {1'b1, 8'd51, 32'h0, 32'd301}};
    n_checks++;
    if (wr_q.size() !== 0) $display("FAIL t4_no_write: got %0d writes want 0", wr_q.size()); else n_pass++;
    n_checks++;
    if (done_q.size() !== 2) $display("FAIL t4_count: got %0d want 2", done_q.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (done_q[i] !== exp_q[i]) $display("FAIL t4_done%0d: got %h want %h", i, done_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_suppress;
    clear_q();
    csr_wr_ready = 1'b1;
    prf_mem[7] = 32'h0;
    push_pkt(mk(8'd7, 32'd400, 8'd40, 4'h2, 1'b0, 32'hAA, 12'h344, 32'h0));
    idle(4);
    n_checks++;
    if (wr_q.size() !== 0) $display("FAIL t5_no_write: got %0d writes want 0", wr_q.size()); else n_pass++;
    exp_q = '{{1'b0, 8'd40, 32'h5, 32'd400}};
    n_checks++;
    if (done_q.size() !== 1 || done_q[0] !== exp_q[0])
      $display("FAIL t5_done: got n=%0d %h want 1 %h", done_q.size(), done_q[0], exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_flush_reset;
    clear_q();
    csr_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_pkt(mk(8'd0, 32'(500 + i), 8'(60 + i), 4'h1, 1'b1, 32'h0, 12'h350, 32'd2));
    n_checks++;
    if (csr_wr_valid !== 1'b1) $display("FAIL t6_stalled: got %b want 1", csr_wr_valid); else n_pass++;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    n_checks++;
    if ({csr_wr_valid, fifo_full, overflow} !== 3'b001)
      $display("FAIL t6_flushed: got %b want 001", {csr_wr_valid, fifo_full, overflow});
    else n_pass++;
    csr_wr_ready = 1'b1;
    idle(4);
    n_checks++;
    if (done_q.size() !== 0 || wr_q.size() !== 0)
      $display("FAIL t6_no_done: got done=%0d wr=%0d want 0 0", done_q.size(), wr_q.size());
    else n_pass++;
    push_pkt(mk(8'd0, 32'd510, 8'd70, 4'h1, 1'b1, 32'h0, 12'h360, 32'd3));
    idle(4);
    n_checks++;
    if (done_q.size() !== 1 || done_q[0][31:0] !== 32'd510 || wr_q[0] !== {12'h360, 32'h3})
      $display("FAIL t6_after_flush: got n=%0d %h %h want 1 inst 510 wr 360/3", done_q.size(), done_q[0], wr_q[0]);
    else n_pass++;
    csr_wr_ready = 1'b0;
    push_pkt(mk(8'd0, 32'd520, 8'd71, 4'h1, 1'b1, 32'h0, 12'h370, 32'd4));
    idle(1);
    n_checks++;
    if (csr_wr_valid !== 1'b1) $display("FAIL t6_pending: got %b want 1", csr_wr_valid); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({csr_wr_valid, CSR_done, CSR_exc, fifo_full, overflow} !== 5'b0)
      $display("FAIL t6_async_flags: got %b want 00000", {csr_wr_valid, CSR_done, CSR_exc, fifo_full, overflow});
    else n_pass++;
    n_checks++;
    if ({CSR_phy, CSR_result, CSR_inst_num, csr_wr_addr, csr_wr_data, prf_rd_addr} !== '0)
      $display("FAIL t6_async_data: got %h want 0", {CSR_phy, CSR_result, CSR_inst_num, csr_wr_addr, csr_wr_data});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    csr_wr_ready = 1'b1;
    idle(4);
    n_checks++;
    if (done_q.size() !== 1 || wr_q.size() !== 1)
      $display("FAIL t6_lost: got done=%0d wr=%0d want 1 1", done_q.size(), wr_q.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; csr_wr_ready = 1'b0; issue_in = '0;
    for (int i = 0; i < 256; i++) prf_mem[i] = 32'h0;
    test_reset();
    test_single_rw();
    test_back_to_back();
    test_stall_overflow();
    test_illegal();
    test_suppress();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
